// File: rtl/eth_mac_tx_arb_pkg.sv
// Shared types and width helpers for the MAC TX frame arbiter.
package eth_mac_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A disabled watchdog still needs a 1-bit counter to keep the logic legal.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/eth_mac_tx_frame_arb_if.sv
// AXI-stream bundle carrying N parallel lanes; N=1 for the MAC side, N=PORTS for the sources.
interface eth_mac_tx_frame_arb_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N-1:0]            tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rr_pick.sv
// Combinational cyclic priority picker: first set request after last_i, wrapping around.
module eth_rr_pick
    import eth_mac_tx_arb_pkg::*;
#(
    parameter int  PORTS = 4,
    localparam int IDX_W = idx_width(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int k = PORTS; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % PORTS]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'((int'(last_i) + k) % PORTS);
            end
        end
    end

endmodule

// File: rtl/eth_mac_tx_frame_arb.sv
// Frame-granular round-robin arbiter feeding the MAC TX stream, with a mid-frame stall watchdog.
module eth_mac_tx_frame_arb
    import eth_mac_tx_arb_pkg::*;
#(
    parameter int PORTS       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int TIMEOUT     = 256
) (
    input  logic                        logic_clk,
    input  logic                        logic_rst_n,
    eth_mac_tx_frame_arb_if.slave       s_axis,
    eth_mac_tx_frame_arb_if.master      m_axis,
    input  logic [PORTS-1:0]            cfg_port_enable,
    output logic [idx_width(PORTS)-1:0] status_grant,
    output logic                        status_busy,
    output logic                        status_abort
);

    localparam int IDX_W = idx_width(PORTS);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_t             state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [CNT_W-1:0]       wd_cnt_q;
    logic [DATA_WIDTH-1:0]  m_tdata_q;
    logic [KEEP_WIDTH-1:0]  m_tkeep_q;
    logic                   m_tvalid_q;
    logic                   m_tlast_q;
    logic                   m_tuser_q;
    logic                   abort_q;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   sel_user;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;
    logic [KEEP_WIDTH-1:0]  beat_keep;
    logic                   out_ready;
    logic                   wd_fire;
    logic                   pass_accept;
    logic [PORTS-1:0]       s_ready;

    eth_rr_pick #(.PORTS(PORTS)) u_pick (
        .req_i   (s_axis.tvalid & cfg_port_enable),
        .last_i  (grant_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign sel_valid = s_axis.tvalid[grant_q];
    assign sel_last  = s_axis.tlast[grant_q];
    assign sel_user  = s_axis.tuser[grant_q];
    assign sel_data  = s_axis.tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep  = s_axis.tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
    assign beat_keep = KEEP_ENABLE ? sel_keep : '1;

    assign out_ready   = !m_tvalid_q || m_axis.tready[0];
    assign wd_fire     = (TIMEOUT != 0) && (state_q == PASS) && (wd_cnt_q == TIMEOUT_CNT) && out_ready;
    assign pass_accept = (state_q == PASS) && sel_valid && out_ready && !wd_fire;

    // The firing cycle withholds ready so a beat arriving then is dropped later in DRAIN, not lost in PASS.
    always_comb begin
        s_ready = '0;
        if ((state_q == PASS && out_ready && !wd_fire) || state_q == DRAIN) begin
            s_ready[grant_q] = 1'b1;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tuser  = m_tuser_q;
    assign status_grant  = grant_q;
    assign status_busy   = (state_q != IDLE);
    assign status_abort  = abort_q;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= IDX_W'(PORTS - 1);
            wd_cnt_q   <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (out_ready) begin
                m_tvalid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    wd_cnt_q <= '0;
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        state_q <= PASS;
                    end
                end
                PASS: begin
                    if (wd_fire) begin
                        m_tdata_q  <= '0;
                        m_tkeep_q  <= '1;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b1;
                        m_tuser_q  <= 1'b1;
                        abort_q    <= 1'b1;
                        wd_cnt_q   <= '0;
                        state_q    <= DRAIN;
                    end else if (pass_accept) begin
                        m_tdata_q  <= sel_data;
                        m_tkeep_q  <= beat_keep;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= sel_last;
                        m_tuser_q  <= sel_user;
                        wd_cnt_q   <= '0;
                        if (sel_last) begin
                            state_q <= IDLE;
                        end
                    end else if (!sel_valid && TIMEOUT != 0 && wd_cnt_q != TIMEOUT_CNT) begin
                        // Backpressured-but-valid cycles neither count nor clear.
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (sel_valid && sel_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_mac_tx_frame_arb.sv
// Directed bench for eth_mac_tx_frame_arb: frame-level model plus per-beat scoreboard.
module tb_eth_mac_tx_frame_arb;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int KW    = 1;
    localparam int TO    = 8;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         gap;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [PORTS-1:0] cfg_en;
    logic [1:0] status_grant;
    logic status_busy;
    logic status_abort;

    always #5 clk = ~clk;

    eth_mac_tx_frame_arb_if #(.N(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
    eth_mac_tx_frame_arb_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

    eth_mac_tx_frame_arb #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .logic_clk       (clk),
        .logic_rst_n     (rst_n),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .cfg_port_enable (cfg_en),
        .status_grant    (status_grant),
        .status_busy     (status_busy),
        .status_abort    (status_abort)
    );

    beat_t      src_q[PORTS][$];
    int         gap_left[PORTS];
    beat_t      exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         abort_cnt = 0;
    int         model_last = PORTS - 1;
    int         obs_cyc[$];
    logic [7:0] obs_data[$];
    logic       obs_last[$];
    int         fire_cyc[$];
    bit         ready_toggle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < PORTS; p++) begin
            if (src_q[p].size() > 0 && gap_left[p] == 0) begin
                s_if.tvalid[p]       = 1'b1;
                s_if.tdata[p*DW +: DW] = src_q[p][0].data;
                s_if.tlast[p]        = src_q[p][0].last;
                s_if.tuser[p]        = src_q[p][0].user;
            end else begin
                s_if.tvalid[p]       = 1'b0;
                s_if.tdata[p*DW +: DW] = '0;
                s_if.tlast[p]        = 1'b0;
                s_if.tuser[p]        = 1'b0;
            end
        end
        s_if.tkeep     = '1;
        m_if.tready[0] = ready_toggle ? cyc[0] : 1'b1;
    endtask

    task automatic load(input int p, input logic [7:0] data, input logic last, input int gap);
        beat_t b;
        b.data = data; b.last = last; b.user = 1'b0; b.gap = gap;
        if (src_q[p].size() == 0) gap_left[p] = gap;
        src_q[p].push_back(b);
    endtask

    task automatic clear_sources();
        for (int p = 0; p < PORTS; p++) begin
            src_q[p].delete();
            gap_left[p] = 0;
        end
    endtask

    task automatic clear_obs();
        obs_cyc.delete(); obs_data.delete(); obs_last.delete(); fire_cyc.delete();
    endtask

    // One clock: observe at the falling edge, then advance sources after the rising edge.
    task automatic step();
        logic [PORTS-1:0] fire;
        beat_t e;
        @(negedge clk);
        check("ready_onehot", 32'($countones(s_if.tready) <= 1), 1);
        if (m_if.tvalid[0] && m_if.tready[0]) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (cycle %0d)", m_if.tdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_if.tdata, e.data);
                check("beat_keep", m_if.tkeep, 1);
                check("beat_last", m_if.tlast, e.last);
                check("beat_user", m_if.tuser, e.user);
            end
            obs_cyc.push_back(cyc); obs_data.push_back(m_if.tdata); obs_last.push_back(m_if.tlast[0]);
        end
        if (status_abort) abort_cnt++;
        fire = s_if.tvalid & s_if.tready;
        if (fire != '0) fire_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < PORTS; p++) begin
            if (fire[p] && src_q[p].size() > 0) begin
                void'(src_q[p].pop_front());
                gap_left[p] = (src_q[p].size() > 0) ? src_q[p][0].gap : 0;
            end else if (gap_left[p] > 0) begin
                gap_left[p]--;
            end
        end
        drive();
    endtask

    task automatic run(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Frame-level model: round-robin over pending enabled frames; a gap of TO or more aborts.
    task automatic model_build(input logic [PORTS-1:0] en);
        int pos[PORTS];
        int p;
        bit found, aborted, first;
        beat_t b, ab;
        ab.data = 8'h00; ab.last = 1'b1; ab.user = 1'b1; ab.gap = 0;
        p = 0;
        for (int i = 0; i < PORTS; i++) pos[i] = 0;
        forever begin
            found = 0;
            for (int k = 1; k <= PORTS && !found; k++) begin
                p = (model_last + k) % PORTS;
                if (en[p] && pos[p] < src_q[p].size()) found = 1;
            end
            if (!found) break;
            model_last = p;
            aborted = 0;
            first = 1;
            do begin
                b = src_q[p][pos[p]];
                pos[p]++;
                if (!first && b.gap >= TO && !aborted) begin
                    exp_q.push_back(ab);
                    aborted = 1;
                end
                if (!aborted) exp_q.push_back(b);
                first = 0;
            end while (!b.last);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int order[5];
        int firsts[$];
        int lasts[$];
        int l0;
        int n;
        beat_t b;
        order = '{0, 1, 2, 3, 0};
        cfg_en = '1;
        clear_sources();
        drive();
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_tlast", m_if.tlast, 0);
        check("rst_tuser", m_if.tuser, 0);
        check("rst_tready", s_if.tready, 0);
        check("rst_busy", status_busy, 0);
        check("rst_abort", status_abort, 0);
        check("rst_grant", status_grant, PORTS - 1);
        rst_n = 1'b1;
        step(); step();

        // Contention: port 0 holds two frames, others one; all present from reset.
        clear_obs();
        for (int p = 0; p < PORTS; p++)
            for (int f = 0; f < ((p == 0) ? 2 : 1); f++)
                for (int i = 0; i < 3; i++)
                    load(p, 8'((p << 6) | (f << 4) | i), i == 2, 0);
        drive();
        model_build(cfg_en);
        run("contention_done", 300);
        for (int i = 0; i < obs_data.size(); i++) begin
            if (i == 0 || obs_last[i-1]) firsts.push_back(i);
            if (obs_last[i]) lasts.push_back(i);
        end
        check("cont_frames", firsts.size(), 5);
        for (int k = 0; k < 5 && k < firsts.size(); k++)
            check("cont_order", 32'(obs_data[firsts[k]] >> 6), order[k]);
        for (int k = 1; k < firsts.size(); k++)
            check("cont_gap", obs_cyc[firsts[k]] - obs_cyc[lasts[k-1]], 2);
        repeat (3) step();

        // Single frame from port 2 with a 1-cycle source-to-output latency.
        clear_obs();
        l0 = cyc;
        for (int i = 0; i < 5; i++) load(2, 8'(8'h11 + i), i == 4, 0);
        drive();
        model_build(cfg_en);
        run("single_done", 50);
        check("single_first_cyc", obs_cyc[0], l0 + 2);
        check("single_latency", obs_cyc[0] - fire_cyc[0], 1);
        check("single_last_cyc", obs_cyc[4], l0 + 6);
        check("single_last_data", obs_data[4], 8'h15);
        check("single_grant", status_grant, 2);
        check("single_idle", status_busy, 0);
        repeat (3) step();

        // 64-beat frame under alternating backpressure must not trip the watchdog.
        clear_obs();
        abort_cnt = 0;
        ready_toggle = 1;
        for (int i = 0; i < 64; i++) load(3, 8'(8'h40 + i), i == 63, 0);
        drive();
        model_build(cfg_en);
        run("bp_done", 400);
        check("bp_beats", obs_data.size(), 64);
        check("bp_no_abort", abort_cnt, 0);
        ready_toggle = 0;
        repeat (4) step();

        // Watchdog: port 1 stalls for TO cycles mid-frame; port 3 waits behind it.
        clear_obs();
        abort_cnt = 0;
        load(1, 8'h21, 0, 0); load(1, 8'h22, 0, 0); load(1, 8'h23, 0, 0);
        load(1, 8'h24, 0, TO); load(1, 8'h25, 0, 0); load(1, 8'h26, 1, 0);
        load(3, 8'h31, 0, 0); load(3, 8'h32, 1, 0);
        drive();
        model_build(cfg_en);
        run("timeout_done", 200);
        check("timeout_abort_cnt", abort_cnt, 1);
        check("timeout_drained", src_q[1].size(), 0);
        check("timeout_abort_data", obs_data[3], 8'h00);
        check("timeout_next_port", obs_data[4], 8'h31);
        repeat (3) step();

        // Enable mask: only ports 0 and 2 may be granted.
        clear_obs();
        cfg_en = 4'b0101;
        for (int p = 0; p < PORTS; p++)
            for (int f = 0; f < 2; f++)
                for (int i = 0; i < 2; i++)
                    load(p, 8'(8'h80 | (p << 4) | (f << 2) | i), i == 1, 0);
        drive();
        model_build(cfg_en);
        run("mask_done", 200);
        repeat (5) step();
        check("mask_p1_pending", src_q[1].size(), 4);
        check("mask_p3_pending", src_q[3].size(), 4);
        check("mask_grant", status_grant, 2);
        clear_sources();
        drive();
        repeat (3) step();

        // Disabling port 0 mid-frame lets the frame finish but blocks its next one.
        clear_obs();
        for (int i = 0; i < 8; i++) load(0, 8'(8'hA0 + i), i == 7, 0);
        load(0, 8'hB0, 0, 0); load(0, 8'hB1, 1, 0);
        drive();
        for (int i = 0; i < 8; i++) begin
            b = src_q[0][i];
            exp_q.push_back(b);
        end
        n = 0;
        while (obs_data.size() < 3 && n < 50) begin step(); n++; end
        cfg_en = 4'b0100;
        run("mask_cut_done", 50);
        repeat (20) step();
        check("mask_cut_pending", src_q[0].size(), 2);
        check("mask_cut_grant", status_grant, 0);
        model_last = 0;
        clear_sources();
        cfg_en = '1;
        drive();
        repeat (3) step();

        // Reset during the second output beat clears everything at once.
        clear_obs();
        for (int i = 0; i < 6; i++) load(3, 8'(8'hC0 + i), i == 5, 0);
        drive();
        model_build(cfg_en);
        n = 0;
        while (obs_data.size() < 2 && n < 50) begin step(); n++; end
        #2 rst_n = 1'b0;
        #1;
        check("mrst_tvalid", m_if.tvalid, 0);
        check("mrst_tdata", m_if.tdata, 0);
        check("mrst_tlast", m_if.tlast, 0);
        check("mrst_tuser", m_if.tuser, 0);
        check("mrst_tready", s_if.tready, 0);
        check("mrst_busy", status_busy, 0);
        check("mrst_grant", status_grant, PORTS - 1);
        clear_sources();
        exp_q.delete();
        model_last = PORTS - 1;
        drive();
        step(); step();
        rst_n = 1'b1;
        clear_obs();
        load(1, 8'hD4, 0, 0); load(1, 8'hD5, 1, 0);
        load(3, 8'hDC, 0, 0); load(3, 8'hDD, 1, 0);
        load(0, 8'hD0, 0, 0); load(0, 8'hD1, 1, 0);
        drive();
        model_build(cfg_en);
        run("post_rst_done", 100);
        check("post_rst_first", obs_data[0], 8'hD0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
